// File: rtl/tube_p_r3_dma_if.sv
// Parasite-side bus bundle for the R3 DMA engine: Tube register pins plus the local memory port.
interface tube_p_r3_dma_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              p_nmi_b;
    logic [2:0]        p_addr;
    logic              p_cs_b;
    logic              p_rdnw;
    logic [DATA_W-1:0] p_data_out;
    logic [DATA_W-1:0] p_data_in;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  p_nmi_b, p_data_in, mem_rdata,
        output p_addr, p_cs_b, p_rdnw, p_data_out, mem_addr, mem_re, mem_we, mem_wdata
    );

    modport slave (
        output p_nmi_b, p_data_in, mem_rdata,
        input  p_addr, p_cs_b, p_rdnw, p_data_out, mem_addr, mem_re, mem_we, mem_wdata
    );
endinterface

// File: rtl/tube_p_r3_dma.sv
// Parasite-end NMI-driven DMA for Tube R3: moves one or two bytes per PNMI between R3 and local memory.
module tube_p_r3_dma #(
    parameter int         ADDR_W       = 16,
    parameter logic [2:0] R3_ADDR      = 3'h5,
    parameter int         GUARD_CYCLES = 1
) (
    input  logic              p_phi2,
    input  logic              p_rst_b,
    input  logic              start,
    input  logic              abort,
    input  logic              dir,
    input  logic              two_byte,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] remaining,
    tube_p_r3_dma_if.master   bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_NMI, S_BUS_RD, S_MEM_WR, S_MEM_RD, S_BUS_WR, S_GUARD, S_FIN
    } state_t;

    localparam logic [ADDR_W-1:0] ONE        = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [1:0]        GUARD_LAST = 2'(GUARD_CYCLES - 1);

    state_t            r_state, w_next, w_after;
    logic              r_dir, r_two, r_second;
    logic [ADDR_W-1:0] r_ptr, r_rem, w_rem_dec;
    logic [1:0]        r_guard;
    logic [7:0]        r_wdata;
    logic              w_load, w_step, w_capture, w_burst, w_bus_act;

    always_ff @(posedge p_phi2 or negedge p_rst_b) begin
        if (!p_rst_b) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_step    = 1'b0;
        w_capture = 1'b0;
        w_burst   = 1'b0;
        w_rem_dec = r_rem - ONE;
        // Second byte of a two-byte burst follows immediately without resampling PNMI.
        if (w_rem_dec == '0)          w_after = S_FIN;
        else if (r_two && !r_second)  w_after = r_dir ? S_MEM_RD : S_BUS_RD;
        else                          w_after = S_GUARD;
        case (r_state)
            S_IDLE: if (start && !abort) begin
                w_load = 1'b1;
                w_next = (length == '0) ? S_FIN : S_WAIT_NMI;
            end
            S_WAIT_NMI: if (!bus.p_nmi_b) begin
                w_burst = 1'b1;
                w_next  = r_dir ? S_MEM_RD : S_BUS_RD;
            end
            S_BUS_RD: begin
                w_capture = 1'b1;
                w_next    = S_MEM_WR;
            end
            S_MEM_WR: begin
                w_step = 1'b1;
                w_next = w_after;
            end
            S_MEM_RD: w_next = S_BUS_WR;
            S_BUS_WR: begin
                w_step = 1'b1;
                w_next = w_after;
            end
            S_GUARD:  if (r_guard == GUARD_LAST) w_next = S_WAIT_NMI;
            S_FIN:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        // A byte already handed to the Tube still counts; a byte only just popped is dropped.
        if (abort && r_state != S_IDLE) begin
            w_next    = S_IDLE;
            w_capture = 1'b0;
            w_burst   = 1'b0;
        end
    end

    always_ff @(posedge p_phi2 or negedge p_rst_b) begin
        if (!p_rst_b) begin
            r_dir    <= 1'b0;
            r_two    <= 1'b0;
            r_second <= 1'b0;
            r_ptr    <= '0;
            r_rem    <= '0;
            r_guard  <= 2'd0;
            r_wdata  <= 8'h00;
        end else begin
            if (w_load) begin
                r_dir    <= dir;
                r_two    <= two_byte;
                r_ptr    <= base_addr;
                r_rem    <= length;
                r_second <= 1'b0;
            end
            if (w_burst) r_second <= 1'b0;
            if (w_step) begin
                r_ptr    <= r_ptr + ONE;
                r_rem    <= w_rem_dec;
                r_second <= 1'b1;
            end
            if (w_capture) r_wdata <= bus.p_data_in;
            r_guard <= (r_state == S_GUARD) ? r_guard + 2'd1 : 2'd0;
        end
    end

    assign w_bus_act      = (r_state == S_BUS_RD) || (r_state == S_BUS_WR);
    assign busy           = (r_state != S_IDLE) && (r_state != S_FIN);
    assign done           = (r_state == S_FIN);
    assign remaining      = r_rem;
    assign bus.p_cs_b     = !w_bus_act;
    assign bus.p_rdnw     = (r_state != S_BUS_WR);
    assign bus.p_addr     = w_bus_act ? R3_ADDR : 3'h0;
    assign bus.p_data_out = (r_state == S_BUS_WR) ? bus.mem_rdata : 8'h00;
    assign bus.mem_re     = (r_state == S_MEM_RD);
    assign bus.mem_we     = (r_state == S_MEM_WR);
    assign bus.mem_addr   = (bus.mem_re || bus.mem_we) ? r_ptr : '0;
    assign bus.mem_wdata  = r_wdata;
endmodule

// File: tb/tb_tube_p_r3_dma.sv
// Directed bench for tube_p_r3_dma: Tube FIFO and memory models around the DUT, immediate-assert checks.
module tb_tube_p_r3_dma;
    logic        clk;
    logic        rst_n;
    logic        start, abort, dir, two_byte;
    logic [15:0] base_addr, length;
    logic        busy, done;
    logic [15:0] remaining;

    tube_p_r3_dma_if #(.ADDR_W(16)) bus ();

    tube_p_r3_dma dut (
        .p_phi2    (clk),
        .p_rst_b   (rst_n),
        .start     (start),
        .abort     (abort),
        .dir       (dir),
        .two_byte  (two_byte),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .remaining (remaining),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment models
    logic [7:0] fifo [16];
    logic [3:0] rd_idx = 4'd0;
    logic [7:0] wmem [0:65535];
    logic [7:0] mem_rdata_r = 8'h00;
    logic [7:0] wr_log [16];
    int         wr_cyc [16];
    logic [3:0] wr_n = 4'd0;
    int rd_cnt = 0, we_cnt = 0, re_cnt = 0, cyc = 0;
    int done_cnt = 0;
    logic busy_at_done = 1'b1;
    logic [15:0] rem_at_done = 16'hFFFF;

    int n_cmp = 0, n_bad = 0;

    function automatic logic [7:0] pattern(input logic [15:0] a);
        if (a == 16'h2000) return 8'hA5;
        if (a == 16'h2001) return 8'h5A;
        return a[7:0] ^ 8'h3C;
    endfunction

    assign bus.p_data_in = fifo[rd_idx];
    assign bus.mem_rdata = mem_rdata_r;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_we) begin
            wmem[bus.mem_addr] <= bus.mem_wdata;
            we_cnt <= we_cnt + 1;
        end
        if (bus.mem_re) begin
            mem_rdata_r <= pattern(bus.mem_addr);
            re_cnt <= re_cnt + 1;
        end
        if (!bus.p_cs_b && bus.p_rdnw) begin
            rd_idx <= rd_idx + 4'd1;
            rd_cnt <= rd_cnt + 1;
        end
        if (!bus.p_cs_b && !bus.p_rdnw) begin
            wr_log[wr_n] <= bus.p_data_out;
            wr_cyc[wr_n] <= cyc;
            wr_n <= wr_n + 4'd1;
        end
    end

    always @(negedge clk) begin
        if (done) begin
            done_cnt     <= done_cnt + 1;
            busy_at_done <= busy;
            rem_at_done  <= remaining;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int rd0, we0, re0, d0;
        logic [3:0] w0;
        logic found;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; dir = 1'b0; two_byte = 1'b0;
        base_addr = 16'h0; length = 16'h0; bus.p_nmi_b = 1'b1;
        for (int i = 0; i < 16; i++) fifo[i] = 8'h00;
        fifo[0] = 8'h11; fifo[1] = 8'h22; fifo[2] = 8'h33; fifo[3] = 8'h44;
        fifo[4] = 8'h55; fifo[5] = 8'h66; fifo[6] = 8'h77;

        repeat (2) @(negedge clk);
        chk("rst_busy",   32'(busy), 0);
        chk("rst_done",   32'(done), 0);
        chk("rst_rem",    32'(remaining), 0);
        chk("rst_cs",     32'(bus.p_cs_b), 1);
        chk("rst_rdnw",   32'(bus.p_rdnw), 1);
        chk("rst_addr",   32'(bus.p_addr), 0);
        chk("rst_pdout",  32'(bus.p_data_out), 0);
        chk("rst_re",     32'(bus.mem_re), 0);
        chk("rst_we",     32'(bus.mem_we), 0);
        chk("rst_maddr",  32'(bus.mem_addr), 0);
        chk("rst_mwdata", 32'(bus.mem_wdata), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Tube->memory, single-byte bursts, NMI pulses with gaps
        rd0 = rd_cnt; we0 = we_cnt; d0 = done_cnt;
        dir = 1'b0; two_byte = 1'b0; base_addr = 16'h1000; length = 16'd3; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("t1_busy", 32'(busy), 1);
        chk("t1_rem_start", 32'(remaining), 3);
        for (int k = 0; k < 3; k++) begin
            bus.p_nmi_b = 1'b0;
            @(negedge clk);
            bus.p_nmi_b = 1'b1;
            if (k == 0) begin
                chk("t1_cs", 32'(bus.p_cs_b), 0);
                chk("t1_paddr", 32'(bus.p_addr), 5);
                chk("t1_rdnw", 32'(bus.p_rdnw), 1);
            end
            repeat (4) @(negedge clk);
        end
        chk("t1_rd_cycles", 32'(rd_cnt - rd0), 3);
        chk("t1_we_count", 32'(we_cnt - we0), 3);
        chk("t1_mem0", 32'(wmem[16'h1000]), 32'h11);
        chk("t1_mem1", 32'(wmem[16'h1001]), 32'h22);
        chk("t1_mem2", 32'(wmem[16'h1002]), 32'h33);
        chk("t1_done_pulses", 32'(done_cnt - d0), 1);
        chk("t1_busy_at_done", 32'(busy_at_done), 0);
        chk("t1_rem_at_done", 32'(rem_at_done), 0);
        chk("t1_busy_after", 32'(busy), 0);

        // Memory->Tube, two-byte burst, NMI withdrawn after first sample
        w0 = wr_n; d0 = done_cnt;
        dir = 1'b1; two_byte = 1'b1; base_addr = 16'h2000; length = 16'd2; start = 1'b1;
        @(negedge clk); start = 1'b0;
        bus.p_nmi_b = 1'b0;
        @(negedge clk);
        chk("t2_memrd_cs", 32'(bus.p_cs_b), 1);
        chk("t2_memrd_re", 32'(bus.mem_re), 1);
        chk("t2_memrd_addr", 32'(bus.mem_addr), 32'h2000);
        bus.p_nmi_b = 1'b1;
        @(negedge clk);
        chk("t2_buswr_cs", 32'(bus.p_cs_b), 0);
        chk("t2_buswr_rdnw", 32'(bus.p_rdnw), 0);
        repeat (5) @(negedge clk);
        chk("t2_writes", 32'(4'(wr_n - w0)), 2);
        chk("t2_data0", 32'(wr_log[w0]), 32'hA5);
        chk("t2_data1", 32'(wr_log[4'(w0 + 4'd1)]), 32'h5A);
        chk("t2_b2b_gap", 32'(wr_cyc[4'(w0 + 4'd1)] - wr_cyc[w0]), 2);
        chk("t2_done_pulses", 32'(done_cnt - d0), 1);

        // Memory->Tube, odd length in two-byte mode: 2 + 1 with guard between
        w0 = wr_n; d0 = done_cnt;
        bus.p_nmi_b = 1'b0;
        dir = 1'b1; two_byte = 1'b1; base_addr = 16'h3000; length = 16'd3; start = 1'b1;
        @(negedge clk); start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin found = 1'b1; break; end
        end
        chk("t3_done_seen", 32'(found), 1);
        @(negedge clk);
        bus.p_nmi_b = 1'b1;
        chk("t3_writes", 32'(4'(wr_n - w0)), 3);
        chk("t3_data0", 32'(wr_log[w0]), 32'h3C);
        chk("t3_data1", 32'(wr_log[4'(w0 + 4'd1)]), 32'h3D);
        chk("t3_data2", 32'(wr_log[4'(w0 + 4'd2)]), 32'h3E);
        chk("t3_gap_in_burst", 32'(wr_cyc[4'(w0 + 4'd1)] - wr_cyc[w0]), 2);
        chk("t3_gap_guard", 32'(wr_cyc[4'(w0 + 4'd2)] - wr_cyc[4'(w0 + 4'd1)]), 4);

        // Empty transfer
        rd0 = rd_cnt; we0 = we_cnt; re0 = re_cnt; w0 = wr_n;
        dir = 1'b0; two_byte = 1'b0; base_addr = 16'h0100; length = 16'd0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("t4_done", 32'(done), 1);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_cs", 32'(bus.p_cs_b), 1);
        @(negedge clk);
        chk("t4_done_end", 32'(done), 0);
        chk("t4_no_bus", 32'(rd_cnt - rd0) + 32'(4'(wr_n - w0)), 0);
        chk("t4_no_mem", 32'(re_cnt - re0) + 32'(we_cnt - we0), 0);

        // Abort on the ending edge of the second BUS_RD
        rd0 = rd_cnt; we0 = we_cnt; d0 = done_cnt;
        bus.p_nmi_b = 1'b0;
        dir = 1'b0; two_byte = 1'b0; base_addr = 16'h4000; length = 16'd4; start = 1'b1;
        @(negedge clk); start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!bus.p_cs_b && bus.p_rdnw && (rd_cnt - rd0) == 1) begin found = 1'b1; break; end
            @(negedge clk);
        end
        chk("t5_reach_byte2", 32'(found), 1);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_rem", 32'(remaining), 3);
        chk("t5_we_now", 32'(bus.mem_we), 0);
        chk("t5_we_count", 32'(we_cnt - we0), 1);
        chk("t5_mem0", 32'(wmem[16'h4000]), 32'h44);
        @(negedge clk);
        chk("t5_no_done", 32'(done_cnt - d0), 0);
        base_addr = 16'h5000; length = 16'd1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin found = 1'b1; break; end
        end
        chk("t5_restart_done", 32'(found), 1);
        chk("t5_restart_mem", 32'(wmem[16'h5000]), 32'h66);

        // Asynchronous reset in the middle of BUS_WR
        @(negedge clk);
        dir = 1'b1; two_byte = 1'b0; base_addr = 16'h6000; length = 16'd2; start = 1'b1;
        @(negedge clk); start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!bus.p_cs_b && !bus.p_rdnw) begin found = 1'b1; break; end
            @(negedge clk);
        end
        chk("t6_reach_buswr", 32'(found), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_cs", 32'(bus.p_cs_b), 1);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_rem", 32'(remaining), 0);
        chk("t6_rst_rdnw", 32'(bus.p_rdnw), 1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.p_nmi_b = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6_idle_busy", 32'(busy), 0);
        chk("t6_idle_cs", 32'(bus.p_cs_b), 1);
        chk("t6_idle_done", 32'(done), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
